// File: rtl/scalar_product_seq.sv
// Sequenced dot product over external X/Y element memories with a pipelined multiply-accumulate.
// Optional overflow detection is built when SCALAR_PRODUCT_SEQ_OVF_EN is defined.
module scalar_product_seq #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 256,
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              abort,
    input  logic [ADDR_W:0]   len,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] result,
    output logic              ovf,
    input  logic              mem_gnt,
    output logic              rd_en,
    output logic [ADDR_W-1:0] rd_addr,
    input  logic [DATA_W-1:0] x_data,
    input  logic [DATA_W-1:0] y_data
);

    localparam int LEN_W = ADDR_W + 1;
    localparam logic [LEN_W-1:0] DEPTH_L = LEN_W'(DEPTH);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t            state;
    logic [ADDR_W-1:0] cnt;
    logic [ADDR_W-1:0] lenm1_q;
    logic              vld_q;
    logic [DATA_W-1:0] acc;
    logic [DATA_W-1:0] acc_next;
    logic [DATA_W-1:0] prod_lo;
    logic [LEN_W-1:0]  len_clip;

    assign len_clip = (len > DEPTH_L) ? DEPTH_L : len;

    // Abort gates the strobe in the same cycle so no read escapes after cancellation.
    assign rd_en   = (state == RUN) && mem_gnt && !abort;
    assign rd_addr = cnt;

`ifdef SCALAR_PRODUCT_SEQ_OVF_EN
    logic [2*DATA_W-1:0] prod_full;
    logic                carry;
    logic                ovf_hit;
    logic                ovf_q;

    assign prod_full          = {{DATA_W{1'b0}}, x_data} * {{DATA_W{1'b0}}, y_data};
    assign prod_lo            = prod_full[DATA_W-1:0];
    assign {carry, acc_next}  = {1'b0, acc} + {1'b0, prod_lo};
    assign ovf_hit            = vld_q && ((|prod_full[2*DATA_W-1:DATA_W]) || carry);
    assign ovf                = ovf_q;

    // Sticky across the whole computation; only a newly accepted start clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (state == IDLE && start) begin
            ovf_q <= 1'b0;
        end else if (ovf_hit) begin
            ovf_q <= 1'b1;
        end
    end
`else
    assign prod_lo  = x_data * y_data;
    assign acc_next = acc + prod_lo;
    assign ovf      = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            lenm1_q <= '0;
            vld_q   <= 1'b0;
            acc     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            result  <= '0;
        end else begin
            done  <= 1'b0;
            vld_q <= rd_en;
            if (vld_q) begin
                acc <= acc_next;
            end

            case (state)
                IDLE: begin
                    if (start) begin
                        acc <= '0;
                        cnt <= '0;
                        if (len_clip == '0) begin
                            state  <= DONE;
                            done   <= 1'b1;
                            result <= '0;
                        end else begin
                            lenm1_q <= ADDR_W'(len_clip - LEN_W'(1));
                            state   <= RUN;
                            busy    <= 1'b1;
                        end
                    end
                end

                RUN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        vld_q <= 1'b0;
                    end else if (mem_gnt) begin
                        cnt <= cnt + ADDR_W'(1);
                        if (cnt == lenm1_q) begin
                            state <= DRAIN;
                        end
                    end
                end

                DRAIN: begin
                    if (abort) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                        vld_q <= 1'b0;
                    end else begin
                        // The final product lands this cycle, so capture the sum including it.
                        state  <= DONE;
                        busy   <= 1'b0;
                        done   <= 1'b1;
                        result <= acc_next;
                    end
                end

                DONE: begin
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_scalar_product_seq.sv
// Directed bench for scalar_product_seq: memory model, per-scenario tasks, expected read-address queue.
module tb_scalar_product_seq;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 256;
    localparam int ADDR_W = 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic              abort = 1'b0;
    logic              mem_gnt = 1'b0;
    logic [ADDR_W:0]   len = '0;
    logic              busy, done, ovf, rd_en;
    logic [DATA_W-1:0] result;
    logic [DATA_W-1:0] x_data = '0;
    logic [DATA_W-1:0] y_data = '0;
    logic [ADDR_W-1:0] rd_addr;

    logic [DATA_W-1:0] xmem [DEPTH];
    logic [DATA_W-1:0] ymem [DEPTH];

    int errors = 0;
    int checks = 0;

    logic [ADDR_W-1:0] exp_q[$];
    logic [ADDR_W-1:0] rd_q[$];
    int                done_q[$];
    bit                rden_log[$];
    int                busy_n;
    logic [DATA_W-1:0] res_done, res_end;
    logic              ovf_done;
    logic              exp_ovf;

    always #5 clk = ~clk;

    // Synchronous element memories: data valid one cycle after the strobe.
    always @(posedge clk) begin
        if (rd_en) begin
            x_data <= xmem[rd_addr];
            y_data <= ymem[rd_addr];
        end
    end

    scalar_product_seq #(.DATA_W(DATA_W), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .len(len),
        .busy(busy), .done(done), .result(result), .ovf(ovf),
        .mem_gnt(mem_gnt), .rd_en(rd_en), .rd_addr(rd_addr),
        .x_data(x_data), .y_data(y_data)
    );

    task automatic clear_mem;
        for (int i = 0; i < DEPTH; i++) begin
            xmem[i] = '0;
            ymem[i] = '0;
        end
    endtask

    // Start is accepted at edge k; loop index c is cycle k+c.
    task automatic run_op(input int l, input bit toggle, input bit hold, input int abort_c, input int ncyc);
        bit g;
        rd_q.delete();
        done_q.delete();
        rden_log.delete();
        busy_n   = 0;
        res_done = '0;
        ovf_done = 1'b0;
        @(posedge clk); #1;
        start = 1'b1;
        len   = l[ADDR_W:0];
        @(posedge clk); #1;
        if (!hold) start = 1'b0;
        g = 1'b1;
        for (int c = 1; c <= ncyc; c++) begin
            mem_gnt = toggle ? g : 1'b1;
            g = ~g;
            abort = (c == abort_c);
            @(negedge clk);
            rden_log.push_back(rd_en);
            if (rd_en) rd_q.push_back(rd_addr);
            if (busy) busy_n++;
            if (done) begin
                done_q.push_back(c);
                res_done = result;
                ovf_done = ovf;
            end
            res_end = result;
            @(posedge clk); #1;
        end
        start   = 1'b0;
        abort   = 1'b0;
        mem_gnt = 1'b0;
    endtask

    task automatic test_reset;
        rst_n   = 1'b0;
        mem_gnt = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (result !== '0) begin errors++; $display("FAIL reset_result: got %0d expected 0", result); end
        checks++; if (ovf !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", ovf); end
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL reset_rd_en: got %b expected 0", rd_en); end
        checks++; if (rd_addr !== '0) begin errors++; $display("FAIL reset_rd_addr: got %0d expected 0", rd_addr); end
        @(posedge clk); #1;
        rst_n   = 1'b1;
        mem_gnt = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b expected 0", busy); end
    endtask

    task automatic test_basic;
        clear_mem();
        for (int i = 0; i < 4; i++) begin
            xmem[i] = DATA_W'(i + 1);
            ymem[i] = DATA_W'(i + 5);
        end
        run_op(4, 1'b0, 1'b0, 0, 10);
        exp_q = '{8'd0, 8'd1, 8'd2, 8'd3};
        checks++; if (rd_q.size() !== exp_q.size()) begin errors++; $display("FAIL basic_nreads: got %0d expected %0d", rd_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rd_q.size(); i++) begin
            checks++; if (rd_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_addr[%0d]: got %0d expected %0d", i, rd_q[i], exp_q[i]); end
        end
        for (int i = 0; i < 4; i++) begin
            checks++; if (rden_log[i] !== 1'b1) begin errors++; $display("FAIL basic_consecutive[%0d]: got %b expected 1", i, rden_log[i]); end
        end
        checks++; if (done_q.size() !== 1) begin errors++; $display("FAIL basic_done_count: got %0d expected 1", done_q.size()); end
        else begin
            checks++; if (done_q[0] !== 6) begin errors++; $display("FAIL basic_done_cycle: got k+%0d expected k+6", done_q[0]); end
        end
        checks++; if (res_done !== 32'd70) begin errors++; $display("FAIL basic_result: got %0d expected 70", res_done); end
        checks++; if (res_end !== 32'd70) begin errors++; $display("FAIL basic_result_held: got %0d expected 70", res_end); end
        checks++; if (ovf_done !== 1'b0) begin errors++; $display("FAIL basic_ovf: got %b expected 0", ovf_done); end
        checks++; if (busy_n !== 5) begin errors++; $display("FAIL basic_busy_cycles: got %0d expected 5", busy_n); end
    endtask

    task automatic test_abort;
        for (int i = 4; i < 8; i++) begin
            xmem[i] = DATA_W'(i + 1);
            ymem[i] = 32'd1;
        end
        run_op(8, 1'b0, 1'b0, 3, 12);
        exp_q = '{8'd0, 8'd1};
        checks++; if (rd_q.size() !== exp_q.size()) begin errors++; $display("FAIL abort_nreads: got %0d expected %0d", rd_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rd_q.size(); i++) begin
            checks++; if (rd_q[i] !== exp_q[i]) begin errors++; $display("FAIL abort_addr[%0d]: got %0d expected %0d", i, rd_q[i], exp_q[i]); end
        end
        checks++; if (rden_log[2] !== 1'b0) begin errors++; $display("FAIL abort_rd_en_gate: got %b expected 0", rden_log[2]); end
        checks++; if (done_q.size() !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses expected 0", done_q.size()); end
        checks++; if (res_end !== 32'd70) begin errors++; $display("FAIL abort_result_kept: got %0d expected 70", res_end); end
        checks++; if (busy_n !== 3) begin errors++; $display("FAIL abort_busy_cycles: got %0d expected 3", busy_n); end
        // 70 + 5+6+7+8
        run_op(8, 1'b0, 1'b0, 0, 14);
        checks++; if (done_q.size() !== 1) begin errors++; $display("FAIL restart_done_count: got %0d expected 1", done_q.size()); end
        else begin
            checks++; if (done_q[0] !== 10) begin errors++; $display("FAIL restart_done_cycle: got k+%0d expected k+10", done_q[0]); end
        end
        checks++; if (res_done !== 32'd96) begin errors++; $display("FAIL restart_result: got %0d expected 96", res_done); end
    endtask

    task automatic test_stall;
        clear_mem();
        xmem[0] = 32'd10; xmem[1] = 32'd20; xmem[2] = 32'd30;
        ymem[0] = 32'd1;  ymem[1] = 32'd1;  ymem[2] = 32'd1;
        run_op(3, 1'b1, 1'b0, 0, 12);
        exp_q = '{8'd0, 8'd1, 8'd2};
        checks++; if (rd_q.size() !== exp_q.size()) begin errors++; $display("FAIL stall_nreads: got %0d expected %0d", rd_q.size(), exp_q.size()); end
        for (int i = 0; i < exp_q.size() && i < rd_q.size(); i++) begin
            checks++; if (rd_q[i] !== exp_q[i]) begin errors++; $display("FAIL stall_addr[%0d]: got %0d expected %0d", i, rd_q[i], exp_q[i]); end
        end
        checks++; if (done_q.size() !== 1) begin errors++; $display("FAIL stall_done_count: got %0d expected 1", done_q.size()); end
        else begin
            checks++; if (done_q[0] !== 7) begin errors++; $display("FAIL stall_done_cycle: got k+%0d expected k+7", done_q[0]); end
        end
        checks++; if (res_done !== 32'd60) begin errors++; $display("FAIL stall_result: got %0d expected 60", res_done); end
    endtask

    task automatic test_zero_len;
        run_op(0, 1'b0, 1'b0, 0, 5);
        checks++; if (rd_q.size() !== 0) begin errors++; $display("FAIL zero_nreads: got %0d expected 0", rd_q.size()); end
        checks++; if (done_q.size() !== 1) begin errors++; $display("FAIL zero_done_count: got %0d expected 1", done_q.size()); end
        else begin
            checks++; if (done_q[0] !== 1) begin errors++; $display("FAIL zero_done_cycle: got k+%0d expected k+1", done_q[0]); end
        end
        checks++; if (res_done !== 32'd0) begin errors++; $display("FAIL zero_result: got %0d expected 0", res_done); end
        checks++; if (busy_n !== 0) begin errors++; $display("FAIL zero_busy: got %0d expected 0", busy_n); end
    endtask

    task automatic test_full_len(input int l, input string tag);
        for (int i = 0; i < DEPTH; i++) begin
            xmem[i] = 32'd254;
            ymem[i] = 32'd254;
        end
        run_op(l, 1'b0, 1'b0, 0, 262);
        checks++; if (rd_q.size() !== 256) begin errors++; $display("FAIL %s_nreads: got %0d expected 256", tag, rd_q.size()); end
        else begin
            checks++; if (rd_q[255] !== 8'd255) begin errors++; $display("FAIL %s_last_addr: got %0d expected 255", tag, rd_q[255]); end
        end
        checks++; if (done_q.size() !== 1) begin errors++; $display("FAIL %s_done_count: got %0d expected 1", tag, done_q.size()); end
        else begin
            checks++; if (done_q[0] !== 258) begin errors++; $display("FAIL %s_done_cycle: got k+%0d expected k+258", tag, done_q[0]); end
        end
        checks++; if (res_done !== 32'd16516096) begin errors++; $display("FAIL %s_result: got %0d expected 16516096", tag, res_done); end
        checks++; if (busy_n !== 257) begin errors++; $display("FAIL %s_busy_cycles: got %0d expected 257", tag, busy_n); end
    endtask

    task automatic test_back_to_back;
        clear_mem();
        xmem[0] = 32'd7;
        ymem[0] = 32'd9;
        // Held start: DONE ignores it, the following IDLE accepts it, giving a 4-cycle period.
        run_op(1, 1'b0, 1'b1, 0, 7);
        checks++; if (done_q.size() !== 2) begin errors++; $display("FAIL b2b_done_count: got %0d expected 2", done_q.size()); end
        else begin
            checks++; if (done_q[0] !== 3) begin errors++; $display("FAIL b2b_done0_cycle: got k+%0d expected k+3", done_q[0]); end
            checks++; if (done_q[1] !== 7) begin errors++; $display("FAIL b2b_done1_cycle: got k+%0d expected k+7", done_q[1]); end
        end
        checks++; if (rd_q.size() !== 2) begin errors++; $display("FAIL b2b_nreads: got %0d expected 2", rd_q.size()); end
        checks++; if (res_done !== 32'd63) begin errors++; $display("FAIL b2b_result: got %0d expected 63", res_done); end
    endtask

    task automatic test_reset_mid;
        @(posedge clk); #1;
        start   = 1'b1;
        len     = 9'd8;
        mem_gnt = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL midreset_busy: got %b expected 0", busy); end
        checks++; if (rd_en !== 1'b0) begin errors++; $display("FAIL midreset_rd_en: got %b expected 0", rd_en); end
        checks++; if (rd_addr !== '0) begin errors++; $display("FAIL midreset_rd_addr: got %0d expected 0", rd_addr); end
        checks++; if (result !== '0) begin errors++; $display("FAIL midreset_result: got %0d expected 0", result); end
        @(posedge clk); #1;
        rst_n   = 1'b1;
        mem_gnt = 1'b0;
    endtask

    task automatic test_ovf;
        clear_mem();
        xmem[0] = 32'h0001_0000; ymem[0] = 32'h0001_0000;
        xmem[1] = 32'hFFFF_FFFF; ymem[1] = 32'd1;
`ifdef SCALAR_PRODUCT_SEQ_OVF_EN
        exp_ovf = 1'b1;
`else
        exp_ovf = 1'b0;
`endif
        run_op(2, 1'b0, 1'b0, 0, 6);
        checks++; if (res_done !== 32'hFFFF_FFFF) begin errors++; $display("FAIL ovf_result: got %h expected ffffffff", res_done); end
        checks++; if (ovf_done !== exp_ovf) begin errors++; $display("FAIL ovf_flag: got %b expected %b", ovf_done, exp_ovf); end
        checks++; if (ovf !== exp_ovf) begin errors++; $display("FAIL ovf_held: got %b expected %b", ovf, exp_ovf); end
        xmem[0] = 32'd3; ymem[0] = 32'd4;
        run_op(1, 1'b0, 1'b0, 0, 5);
        checks++; if (ovf_done !== 1'b0) begin errors++; $display("FAIL ovf_cleared: got %b expected 0", ovf_done); end
        checks++; if (res_done !== 32'd12) begin errors++; $display("FAIL ovf_next_result: got %0d expected 12", res_done); end
    endtask

    initial begin
        clear_mem();
        test_reset();
        test_basic();
        test_abort();
        test_stall();
        test_zero_len();
        test_full_len(256, "full");
        test_full_len(300, "clip");
        test_back_to_back();
        test_reset_mid();
        test_ovf();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
